// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU pipeline definitions: stall encodings, control FSM states and
// the default exception handler address.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_t;

    // Hold vectors: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // Deepest requesting stage wins; result is always a low-order run of ones.
    function automatic logic [5:0] stall_encode(input logic req_mem,
                                                input logic req_ex,
                                                input logic req_id);
        logic [5:0] enc;
        enc = STALL_NONE;
        if (req_mem) begin
            enc = STALL_MEM;
        end else if (req_ex) begin
            enc = STALL_EX;
        end else if (req_id) begin
            enc = STALL_ID;
        end
        return enc;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_wdt.sv
// Stall watchdog: counts consecutive stalled edges and raises a sticky flag
// once the count reaches WDT_LIMIT.
module stall_wdt #(
    parameter int WDT_LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam logic [31:0] LIMIT = 32'(WDT_LIMIT);

    logic [31:0] count_reg;
    logic        timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= 32'd0;
            timeout_reg <= 1'b0;
        end else if (!active || clear) begin
            count_reg <= 32'd0;
        end else begin
            // Hold at the limit so a very long stall cannot wrap the count.
            if (count_reg < LIMIT) begin
                count_reg <= count_reg + 32'd1;
            end
            if (count_reg + 32'd1 >= LIMIT) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: priority stall encoding, one-cycle
// flush with redirect, saturating stall statistics and a stall watchdog.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          WDT_LIMIT  = 1023,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic        exception_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        wdt_timeout
);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;
    logic [31:0] stall_cycles_reg;
    logic [5:0]  stall_vec;
    logic        any_req;
    logic        stall_active;
    logic        in_flush;

    assign in_flush     = (state_reg == ST_FLUSH);
    assign any_req      = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
    assign stall_active = |stall_vec;

    always_comb begin
        stall_vec  = stall_encode(stallreq_from_mem, stallreq_from_ex, stallreq_from_id);
        state_next = state_reg;
        // The flush cycle clears every register, so nothing may be held.
        if (in_flush) begin
            stall_vec = STALL_NONE;
        end
        case (state_reg)
            ST_RUN, ST_STALL: begin
                if (exception_i) begin
                    state_next = ST_FLUSH;
                end else if (stall_active) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (exception_i) begin
                    state_next = ST_FLUSH;
                end else if (any_req) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_RUN;
            stall_cycles_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (stall_active && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    stall_wdt #(
        .WDT_LIMIT(WDT_LIMIT)
    ) u_stall_wdt (
        .clk     (clk),
        .rst     (rst),
        .active  (stall_active),
        .clear   (in_flush),
        .timeout (wdt_timeout)
    );

    assign stall        = stall_vec;
    assign flush        = in_flush;
    assign new_pc       = in_flush ? EXC_VECTOR : 32'd0;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic        exception_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        wdt_timeout;

    typedef struct packed {
        int          id;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cyc;
        logic        wdt;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic stim_done;
    int   step_id;

    pipeline_ctrl #(
        .WDT_LIMIT  (4),
        .EXC_VECTOR (32'h0000_0020)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_id  (stallreq_from_id),
        .stallreq_from_ex  (stallreq_from_ex),
        .stallreq_from_mem (stallreq_from_mem),
        .exception_i       (exception_i),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles      (stall_cycles),
        .wdt_timeout       (wdt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, record what the outputs must be this cycle.
    task automatic step(input logic r, input logic x, input logic m,
                        input logic e, input logic i,
                        input logic [5:0] es, input logic ef,
                        input logic [31:0] epc, input logic [31:0] ecyc,
                        input logic ew);
        exp_t ex;
        rst               = r;
        exception_i       = x;
        stallreq_from_mem = m;
        stallreq_from_ex  = e;
        stallreq_from_id  = i;
        ex.id    = step_id;
        ex.stall = es;
        ex.flush = ef;
        ex.pc    = epc;
        ex.cyc   = ecyc;
        ex.wdt   = ew;
        exp_q.push_back(ex);
        step_id = step_id + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_done         = 1'b0;
        step_id           = 0;
        rst               = 1'b1;
        exception_i       = 1'b0;
        stallreq_from_mem = 1'b0;
        stallreq_from_ex  = 1'b0;
        stallreq_from_id  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        //    rst  exc  mem  ex   id   stall      flush pc        cycles        wdt
        step(1'b1,1'b0,1'b0,1'b0,1'b1, 6'b000111, 1'b0, 32'h0,   32'd0,        1'b0); // 0 reset, stall combinational
        step(1'b0,1'b0,1'b0,1'b0,1'b1, 6'b000111, 1'b0, 32'h0,   32'd0,        1'b0); // 1 id
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd1,        1'b0); // 2
        step(1'b0,1'b0,1'b1,1'b1,1'b1, 6'b011111, 1'b0, 32'h0,   32'd1,        1'b0); // 3 all
        step(1'b0,1'b0,1'b0,1'b1,1'b1, 6'b001111, 1'b0, 32'h0,   32'd2,        1'b0); // 4 drop mem
        step(1'b0,1'b0,1'b0,1'b0,1'b1, 6'b000111, 1'b0, 32'h0,   32'd3,        1'b0); // 5
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd4,        1'b0); // 6
        step(1'b0,1'b1,1'b0,1'b1,1'b0, 6'b001111, 1'b0, 32'h0,   32'd4,        1'b0); // 7 exc + ex
        step(1'b0,1'b0,1'b0,1'b1,1'b0, 6'b000000, 1'b1, 32'h20,  32'd5,        1'b0); // 8 flush
        step(1'b0,1'b0,1'b0,1'b1,1'b0, 6'b001111, 1'b0, 32'h0,   32'd5,        1'b0); // 9 back to stall
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd6,        1'b0); // 10
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'd6,        1'b0); // 11 wdt run
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'd7,        1'b0); // 12
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'd8,        1'b0); // 13
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'd9,        1'b0); // 14
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd10,       1'b1); // 15 wdt fired
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd10,       1'b1); // 16 sticky
        step(1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd10,       1'b1); // 17 exc
        step(1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000, 1'b1, 32'h20,  32'd10,       1'b1); // 18 exc during flush
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b1, 32'h20,  32'd10,       1'b1); // 19 second flush
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd10,       1'b1); // 20
        step(1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd10,       1'b1); // 21 exc
        step(1'b1,1'b0,1'b1,1'b0,1'b0, 6'b000000, 1'b1, 32'h20,  32'd10,       1'b1); // 22 rst mid-flush
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'd0,        1'b0); // 23 cleared
        force dut.stall_cycles_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_reg;
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'hFFFF_FFFE, 1'b0); // 24 preload
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0); // 25
        step(1'b0,1'b0,1'b1,1'b0,1'b0, 6'b011111, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0); // 26 saturated
        step(1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0); // 27
        stim_done = 1'b1;
    end

    int   idle_cycles;
    int   total_cycles;
    exp_t cur;

    initial begin
        checks       = 0;
        errors       = 0;
        idle_cycles  = 0;
        total_cycles = 0;
    end

    always @(negedge clk) begin
        total_cycles = total_cycles + 1;
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks = checks + 5;
            if (stall !== cur.stall) begin
                errors = errors + 1;
                $display("FAIL step %0d stall: got %b expected %b", cur.id, stall, cur.stall);
            end
            if (flush !== cur.flush) begin
                errors = errors + 1;
                $display("FAIL step %0d flush: got %b expected %b", cur.id, flush, cur.flush);
            end
            if (new_pc !== cur.pc) begin
                errors = errors + 1;
                $display("FAIL step %0d new_pc: got %h expected %h", cur.id, new_pc, cur.pc);
            end
            if (stall_cycles !== cur.cyc) begin
                errors = errors + 1;
                $display("FAIL step %0d stall_cycles: got %h expected %h", cur.id, stall_cycles, cur.cyc);
            end
            if (wdt_timeout !== cur.wdt) begin
                errors = errors + 1;
                $display("FAIL step %0d wdt_timeout: got %b expected %b", cur.id, wdt_timeout, cur.wdt);
            end
            $display("step %0d: stall=%b flush=%b new_pc=%h stall_cycles=%h wdt=%b",
                     cur.id, stall, flush, new_pc, stall_cycles, wdt_timeout);
        end else if (stim_done) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else begin
            idle_cycles = idle_cycles + 1;
        end
        if (idle_cycles > 20 || total_cycles > 2000) begin
            errors = errors + 1;
            $display("FAIL timeout: got %0d idle cycles expected stimulus to complete", idle_cycles);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

endmodule
